// File: rtl/pwm_fade.sv
// pwm_fade: walks a duty value toward a CPU-written target, one step per
// interval, and pushes each new value into the downstream pwm block.
module pwm_fade #(
   parameter int TICK_DIV = 1112,
   parameter int STEP_W   = 16,
   parameter int MAX_DUTY = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        A,
   input  logic [31:0] WD,
   input  logic        WE,
   output logic [31:0] RD,
   output logic [6:0]  DUTY,
   output logic        DUTY_WE,
   output logic        BUSY,
   output logic        DONE
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [6:0] MAXD = 7'(MAX_DUTY);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      RAMP,
      LOAD
   } state_t;

   state_t state, nxt;

   logic [PW-1:0]     pre;
   logic              tick;
   logic [6:0]        cur, cur_n;
   logic [6:0]        tgt, tgt_n;
   logic [STEP_W-1:0] step;
   logic [STEP_W-1:0] icnt, icnt_n;
   logic [STEP_W-1:0] eff_step;
   logic [STEP_W:0]   cnt_inc;
   logic              due;
   logic              we_q, we_n;
   logic              done_q, done_n;
   logic              wr_t, wr_s, jump;
   logic [6:0]        wd_clamp;
   logic [6:0]        step_val;
   logic              unused_wd;

   assign unused_wd = ^WD[31:STEP_W];

   assign wr_t     = WE && !A;
   assign wr_s     = WE && A;
   assign jump     = wr_t && WD[7];
   assign wd_clamp = (WD[6:0] > MAXD) ? MAXD : WD[6:0];

   assign tick     = (pre == PMAX);
   assign eff_step = (step == '0) ? STEP_W'(1) : step;
   assign cnt_inc  = {1'b0, icnt} + 1'b1;
   // >= rather than == so a shrunken STEP fires on the next tick
   assign due      = tick && (cnt_inc >= {1'b0, eff_step});

   always_comb begin
      step_val = cur;
      if (tgt > cur)
         step_val = cur + 7'd1;
      else if (tgt < cur)
         step_val = cur - 7'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step <= STEP_W'(1);
      end else if (wr_s) begin
         step <= WD[STEP_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= INIT;
         cur    <= '0;
         tgt    <= '0;
         icnt   <= '0;
         we_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= nxt;
         cur    <= cur_n;
         tgt    <= tgt_n;
         icnt   <= icnt_n;
         we_q   <= we_n;
         done_q <= done_n;
      end
   end

   // strobes are registered, so they appear in the cycle after the decision
   always_comb begin
      nxt    = state;
      cur_n  = cur;
      tgt_n  = tgt;
      icnt_n = icnt;
      we_n   = 1'b0;
      done_n = 1'b0;
      if (wr_t)
         tgt_n = wd_clamp;
      unique case (state)
         INIT, IDLE, LOAD: begin
            nxt = IDLE;
            if (state == INIT)
               we_n = 1'b1;
            if (jump) begin
               cur_n  = wd_clamp;
               nxt    = LOAD;
               we_n   = 1'b1;
               done_n = 1'b1;
            end else if (wr_t && wd_clamp != cur) begin
               nxt    = RAMP;
               icnt_n = '0;
            end
         end
         RAMP: begin
            if (jump) begin
               cur_n  = wd_clamp;
               nxt    = LOAD;
               we_n   = 1'b1;
               done_n = 1'b1;
            end else begin
               if (tick)
                  icnt_n = cnt_inc[STEP_W-1:0];
               if (due) begin
                  icnt_n = '0;
                  cur_n  = step_val;
                  we_n   = 1'b1;
                  if (step_val == tgt_n) begin
                     nxt    = IDLE;
                     done_n = 1'b1;
                  end
               end else if (wr_t && wd_clamp == cur) begin
                  nxt = IDLE;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   assign DUTY    = cur;
   assign DUTY_WE = we_q;
   assign DONE    = done_q;
   assign BUSY    = (state == RAMP);

   assign RD = A ? 32'(step)
                 : {BUSY, 16'b0, cur, 1'b0, tgt};

endmodule

// File: tb/tb_pwm_fade.sv
// tb_pwm_fade: directed checks of the duty ramp engine
// with a short prescaler.
module tb_pwm_fade;

   logic        clk;
   logic        rst;
   logic        A;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] RD;
   logic [6:0]  DUTY;
   logic        DUTY_WE;
   logic        BUSY;
   logic        DONE;

   int checks = 0;
   int errors = 0;

   pwm_fade #(
      .TICK_DIV(4),
      .STEP_W  (16),
      .MAX_DUTY(100)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .WD     (WD),
      .WE     (WE),
      .RD     (RD),
      .DUTY   (DUTY),
      .DUTY_WE(DUTY_WE),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic a, input logic [31:0] d);
      @(negedge clk);
      A  = a;
      WD = d;
      WE = 1'b1;
      @(negedge clk);
      WE = 1'b0;
      A  = 1'b0;
   endtask

   task automatic wait_we(input int lim,
                          output logic [6:0] d,
                          output logic dn,
                          output int n);
      n = 0;
      while (!DUTY_WE && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (!DUTY_WE)
         chk("strobe_timeout", 32'd0, 32'd1);
      d  = DUTY;
      dn = DONE;
      @(negedge clk);
      n++;
   endtask

   task automatic quiet(input string tag, input int cyc);
      int ev;
      ev = 0;
      for (int i = 0; i < cyc; i++) begin
         @(negedge clk);
         if (DUTY_WE || DONE)
            ev++;
      end
      chk(tag, 32'(ev), 32'd0);
   endtask

   initial begin
      logic [6:0] d;
      logic       dn;
      int         n;

      rst = 1'b0;
      A   = 1'b0;
      WD  = '0;
      WE  = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_duty", 32'(DUTY), 32'd0);
      chk("rst_we", 32'(DUTY_WE), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("init_we", 32'(DUTY_WE), 32'd1);
      chk("init_duty", 32'(DUTY), 32'd0);
      @(negedge clk);
      chk("init_we_off", 32'(DUTY_WE), 32'd0);
      chk("init_busy", 32'(BUSY), 32'd0);
      chk("init_rd0", RD, 32'd0);
      A = 1'b1;
      #1 chk("init_rd1", RD, 32'd1);
      A = 1'b0;

      // basic ramp 0 -> 3, step 1
      wr(1'b1, 32'd1);
      wr(1'b0, 32'd3);
      chk("r3_busy", 32'(BUSY), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         wait_we(100, d, dn, n);
         chk("r3_duty", 32'(d), 32'(k));
         chk("r3_done", 32'(dn), (k == 3) ? 32'd1 : 32'd0);
         if (k > 1)
            chk("r3_space", 32'(n), 32'd4);
      end
      chk("r3_idle", 32'(BUSY), 32'd0);

      // clamp at 100
      wr(1'b0, 32'h80 | 32'd98);
      wait_we(10, d, dn, n);
      chk("j98_duty", 32'(d), 32'd98);
      chk("j98_done", 32'(dn), 32'd1);
      wr(1'b0, 32'd120);
      chk("clamp_rd", RD, 32'h8000_6264);
      wait_we(100, d, dn, n);
      chk("clamp_99", 32'(d), 32'd99);
      wait_we(100, d, dn, n);
      chk("clamp_100", 32'(d), 32'd100);
      chk("clamp_done", 32'(dn), 32'd1);
      quiet("clamp_quiet", 40);
      chk("clamp_rd2", RD, 32'h0000_6464);

      // reverse mid-ramp
      wr(1'b0, 32'h80);
      wait_we(10, d, dn, n);
      chk("j0_duty", 32'(d), 32'd0);
      wr(1'b0, 32'd50);
      for (int k = 1; k <= 10; k++) begin
         wait_we(100, d, dn, n);
         chk("up_duty", 32'(d), 32'(k));
         chk("up_done", 32'(dn), 32'd0);
      end
      wr(1'b0, 32'd5);
      for (int k = 9; k >= 5; k--) begin
         wait_we(100, d, dn, n);
         chk("dn_duty", 32'(d), 32'(k));
         chk("dn_done", 32'(dn), (k == 5) ? 32'd1 : 32'd0);
      end
      chk("dn_idle", 32'(BUSY), 32'd0);

      // jump 20 -> 60
      wr(1'b0, 32'h80 | 32'd20);
      wait_we(10, d, dn, n);
      chk("j20_duty", 32'(d), 32'd20);
      wr(1'b0, 32'h80 | 32'd60);
      wait_we(10, d, dn, n);
      chk("j60_duty", 32'(d), 32'd60);
      chk("j60_done", 32'(dn), 32'd1);
      chk("j60_imm", 32'(n), 32'd1);
      quiet("j60_quiet", 20);

      // step 0 acts as 1, then reset mid-ramp
      wr(1'b0, 32'h80);
      wait_we(10, d, dn, n);
      wr(1'b1, 32'd0);
      A = 1'b1;
      #1 chk("s0_rd", RD, 32'd0);
      A = 1'b0;
      wr(1'b0, 32'd10);
      for (int k = 1; k <= 7; k++) begin
         wait_we(100, d, dn, n);
         chk("s0_duty", 32'(d), 32'(k));
         if (k > 1)
            chk("s0_space", 32'(n), 32'd4);
      end
      chk("pre_rst_duty", 32'(DUTY), 32'd7);
      rst = 1'b1;
      #1;
      chk("arst_duty", 32'(DUTY), 32'd0);
      chk("arst_busy", 32'(BUSY), 32'd0);
      chk("arst_we", 32'(DUTY_WE), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reinit_we", 32'(DUTY_WE), 32'd1);
      chk("reinit_duty", 32'(DUTY), 32'd0);
      A = 1'b1;
      #1 chk("reinit_step", RD, 32'd1);
      A = 1'b0;
      @(negedge clk);
      chk("reinit_we_off", 32'(DUTY_WE), 32'd0);

      // retarget to current value stops silently
      wr(1'b0, 32'd10);
      for (int k = 1; k <= 3; k++) begin
         wait_we(100, d, dn, n);
         chk("rt_duty", 32'(d), 32'(k));
      end
      wr(1'b0, 32'd3);
      quiet("rt_quiet", 20);
      chk("rt_busy", 32'(BUSY), 32'd0);
      chk("rt_rd", RD, 32'h0000_0303);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
